// File: rtl/matrix_sequencer.sv
// -----------------------------------------------------------------------------
// matrix_sequencer
//
// Microcode sequencer for the math box. Steps through an external program ROM
// one instruction every STEP_CYCLES ready cycles, decodes the eight instruction
// strobes, and forms the matrix-RAM address from the instruction word and the
// block index counter (BIC). A CPU write to start_wr loads the program address
// and starts a run; the run ends on an mhalt instruction (done pulse).
//
// Optional feature: define MATRIX_SEQ_WATCHDOG_EN to build a watchdog that
// aborts a run after WDOG_STEPS instructions without mhalt and raises a
// sticky fault flag. Without the macro, fault is tied low.
//
// Ports:
//   clk_12     system clock
//   reset      asynchronous, active-high
//   start_wr   CPU write: load pa from cpu_data and start/restart a run
//   bic_lo_wr  CPU write: BIC[7:0] <= cpu_data
//   bic_hi_wr  CPU write: BIC[BIC_W-1:8] <= cpu_data (no effect if BIC_W<=8)
//   cpu_data   CPU write data
//   macflag    datapath ready; low holds the step phase
//   ip         instruction word from ROM (one-cycle latency from pa)
//   pa         program address to ROM
//   ma         matrix RAM address (combinational)
//   lac..lda   instruction strobes ip[8..15] qualified by wp
//   wp         one-cycle write pulse per instruction
//   busy       high while running
//   done       one-cycle pulse after a normal halt
//   fault      sticky watchdog abort flag
// -----------------------------------------------------------------------------
module matrix_sequencer #(
    parameter int PA_W        = 10,
    parameter int BIC_W       = 9,
    parameter int DIRECT_W    = 5,
    parameter int STEP_CYCLES = 4,
    parameter int WDOG_STEPS  = 1024
) (
    input  logic              clk_12,
    input  logic              reset,
    input  logic              start_wr,
    input  logic              bic_lo_wr,
    input  logic              bic_hi_wr,
    input  logic [7:0]        cpu_data,
    input  logic              macflag,
    input  logic [15:0]       ip,
    output logic [PA_W-1:0]   pa,
    output logic [BIC_W+1:0]  ma,
    output logic              lac,
    output logic              lw,
    output logic              mhalt,
    output logic              incbic,
    output logic              clearacc,
    output logic              ldc,
    output logic              ldb,
    output logic              lda,
    output logic              wp,
    output logic              busy,
    output logic              done,
    output logic              fault
);

    localparam int PH_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int IN_W = PA_W - 2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [PA_W-1:0]   pa_q, pa_d;
    logic [BIC_W-1:0]  bic_q, bic_d;
    logic              done_q, done_d;

    logic              run;
    logic              wp_int;
    logic [7:0]        strobes;
    logic              abort;
    logic [PA_W-1:0]   pa_load;
    logic [IN_W-1:0]   inpage_next;

    // Step decode. A start_wr cycle never issues a write pulse, so a restart
    // or a start racing an mhalt cannot fire a stale instruction.
    always_comb begin
        run     = (state_q == S_RUN);
        wp_int  = run & macflag & ~start_wr & (phase_q == PH_W'(STEP_CYCLES - 1));
        strobes = ip[15:8] & {8{wp_int}};
    end

    // CPU byte lands left-justified: top two bits are the page, the rest fill
    // the in-page counter from its MSB, low (PA_W-8) bits cleared.
    always_comb begin
        pa_load = '0;
        for (int i = 0; i < PA_W; i++) begin
            int idx;
            idx = i - (PA_W - 8);
            if (idx >= 0) pa_load[i] = cpu_data[idx[2:0]];
        end
    end

    // In-page increment; page bits are untouched so the count wraps in-page.
    always_comb begin
        inpage_next = pa_q[IN_W-1:0] + IN_W'(1);
    end

    // FSM next state, phase and program address.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        pa_d    = pa_q;
        done_d  = 1'b0;
        if (start_wr) begin
            state_d = S_RUN;
            phase_d = '0;
            pa_d    = pa_load;
        end else if (run) begin
            if (wp_int) begin
                phase_d = '0;
                pa_d    = {pa_q[PA_W-1:PA_W-2], inpage_next};
                if (strobes[2]) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (abort) begin
                    state_d = S_IDLE;
                end
            end else if (macflag) begin
                phase_d = phase_q + PH_W'(1);
            end
        end
    end

    // BIC: increment strobe beats the low-byte write, which beats the high write.
    always_comb begin
        bic_d = bic_q;
        if (strobes[3]) begin
            bic_d = bic_q + BIC_W'(1);
        end else if (bic_lo_wr) begin
            for (int i = 0; i < BIC_W; i++) begin
                if (i < 8) bic_d[i] = cpu_data[i[2:0]];
            end
        end else if (bic_hi_wr) begin
            for (int i = 0; i < BIC_W; i++) begin
                if (i >= 8 && i < 16) bic_d[i] = cpu_data[i[2:0]];
            end
        end
    end

    always_ff @(posedge clk_12 or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            pa_q    <= '0;
            bic_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            pa_q    <= pa_d;
            bic_q   <= bic_d;
            done_q  <= done_d;
        end
    end

`ifdef MATRIX_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_STEPS + 1);

    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            fault_q, fault_d;

    // Abort fires on the WDOG_STEPS-th write pulse of a run unless that
    // instruction is itself the halt.
    always_comb begin
        abort   = wp_int & ~strobes[2] & (wdog_q == WD_W'(WDOG_STEPS - 1));
        wdog_d  = wdog_q;
        fault_d = fault_q;
        if (start_wr) begin
            wdog_d  = '0;
            fault_d = 1'b0;
        end else begin
            if (wp_int) wdog_d = wdog_q + WD_W'(1);
            if (abort)  fault_d = 1'b1;
        end
    end

    always_ff @(posedge clk_12 or posedge reset) begin
        if (reset) begin
            wdog_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            wdog_q  <= wdog_d;
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    assign abort = 1'b0;
    assign fault = 1'b0;
`endif

    // Matrix address: upper BIC bits always, middle field either direct from
    // the instruction or from the low BIC bits, bottom two bits from ip.
    assign ma = {bic_q[BIC_W-1:DIRECT_W],
                 ip[7] ? ip[DIRECT_W+1:2] : bic_q[DIRECT_W-1:0],
                 ip[1:0]};

    assign pa       = pa_q;
    assign wp       = wp_int;
    assign lac      = strobes[0];
    assign lw       = strobes[1];
    assign mhalt    = strobes[2];
    assign incbic   = strobes[3];
    assign clearacc = strobes[4];
    assign ldc      = strobes[5];
    assign ldb      = strobes[6];
    assign lda      = strobes[7];
    assign busy     = run;
    assign done     = done_q;

endmodule
